// File: rtl/storage_reader_if.sv
// Output word stream of storage_reader: valid/ready handshake plus frame/point tags.
// Master drives the word and valid; slave drives ready.
interface storage_reader_if;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_frame;
  logic [10:0] out_point;
  logic        out_last;

  modport master (
    output out_valid, out_data, out_frame, out_point, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_frame, out_point, out_last,
    output out_ready
  );
endinterface

// File: rtl/storage_reader.sv
// Snapshots the frame storage on start and streams every word frame by frame, point by point.
// Latency: first word valid the cycle after start, then one word per accepted cycle with no bubbles.
// Backpressure: word held stable while out_ready is low; STORAGE_READER_SUM_EN appends per-point sum words.
module storage_reader #(
  parameter int POINTS = 10,
  parameter int FRAMES = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [12*POINTS*FRAMES-1:0]  storage,
  output logic                         busy,
  output logic                         done,
  storage_reader_if.master             rd
);

  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int PW = (POINTS > 1) ? $clog2(POINTS) : 1;
  localparam logic [FW-1:0] F_LAST = FW'(FRAMES - 1);
  localparam logic [PW-1:0] P_LAST = PW'(POINTS - 1);
`ifdef STORAGE_READER_SUM_EN
  localparam logic FIRST_IS_LAST = 1'b0;
`else
  localparam logic FIRST_IS_LAST = (FRAMES == 1) && (POINTS == 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
`ifdef STORAGE_READER_SUM_EN
    S_SUM,
`endif
    S_DONE
  } state_t;

  state_t        state;
  logic [11:0]   snap [FRAMES][POINTS];
  logic [FW-1:0] frame_q;
  logic [FW-1:0] nxt_frame;
  logic [PW-1:0] point_q;
  logic [PW-1:0] nxt_point;
  logic [11:0]   nxt_word;
  logic          accept;

  assign accept = rd.out_valid & rd.out_ready;

  // Index of the word that follows the one currently presented.
  always_comb begin
    nxt_point = point_q + PW'(1);
    nxt_frame = frame_q;
    if (point_q == P_LAST) begin
      nxt_point = '0;
      nxt_frame = frame_q + FW'(1);
    end
  end

  assign nxt_word = snap[nxt_frame][nxt_point];

`ifdef STORAGE_READER_SUM_EN
  // Column sum for the next point; 16 frames of 0xFFF still fit in 16 bits.
  logic [15:0] nxt_sum;
  always_comb begin
    nxt_sum = '0;
    for (int f = 0; f < FRAMES; f++) begin
      nxt_sum = nxt_sum + 16'(snap[f][nxt_point]);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      frame_q      <= '0;
      point_q      <= '0;
      rd.out_valid <= 1'b0;
      rd.out_data  <= '0;
      rd.out_frame <= '0;
      rd.out_point <= '0;
      rd.out_last  <= 1'b0;
      for (int f = 0; f < FRAMES; f++) begin
        for (int p = 0; p < POINTS; p++) begin
          snap[f][p] <= '0;
        end
      end
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int f = 0; f < FRAMES; f++) begin
              for (int p = 0; p < POINTS; p++) begin
                snap[f][p] <= storage[12*(POINTS*f+p) +: 12];
              end
            end
            frame_q      <= '0;
            point_q      <= '0;
            busy         <= 1'b1;
            rd.out_valid <= 1'b1;
            rd.out_data  <= {4'b0, storage[11:0]};
            rd.out_frame <= '0;
            rd.out_point <= '0;
            rd.out_last  <= FIRST_IS_LAST;
            state        <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (accept) begin
            if (frame_q == F_LAST && point_q == P_LAST) begin
`ifdef STORAGE_READER_SUM_EN
              point_q      <= '0;
              rd.out_data  <= nxt_sum;
              rd.out_frame <= 4'hF;
              rd.out_point <= '0;
              rd.out_last  <= (P_LAST == '0);
              state        <= S_SUM;
`else
              rd.out_valid <= 1'b0;
              rd.out_last  <= 1'b0;
              done         <= 1'b1;
              state        <= S_DONE;
`endif
            end else begin
              frame_q      <= nxt_frame;
              point_q      <= nxt_point;
              rd.out_data  <= {4'b0, nxt_word};
              rd.out_frame <= 4'(nxt_frame);
              rd.out_point <= 11'(nxt_point);
`ifdef STORAGE_READER_SUM_EN
              rd.out_last  <= 1'b0;
`else
              rd.out_last  <= (nxt_frame == F_LAST) && (nxt_point == P_LAST);
`endif
            end
          end
        end
`ifdef STORAGE_READER_SUM_EN
        S_SUM: begin
          if (accept) begin
            if (point_q == P_LAST) begin
              rd.out_valid <= 1'b0;
              rd.out_last  <= 1'b0;
              done         <= 1'b1;
              state        <= S_DONE;
            end else begin
              point_q      <= nxt_point;
              rd.out_data  <= nxt_sum;
              rd.out_point <= 11'(nxt_point);
              rd.out_last  <= (nxt_point == P_LAST);
            end
          end
        end
`endif
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_storage_reader.sv
// Randomized and directed readouts of storage_reader checked against a queue-based reference model.
// Builds with or without STORAGE_READER_SUM_EN.
module tb_storage_reader;
  localparam int POINTS = 2;
  localparam int FRAMES = 10;
`ifdef STORAGE_READER_SUM_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif
  localparam int NWORDS = FRAMES*POINTS + (SUM_EN ? POINTS : 0);

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  f;
    logic [10:0] p;
    logic        l;
  } word_t;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        start = 1'b0;
  logic [12*POINTS*FRAMES-1:0] storage = '0;
  logic                        busy;
  logic                        done;

  storage_reader_if rd();

  storage_reader #(.POINTS(POINTS), .FRAMES(FRAMES)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .storage (storage),
    .busy    (busy),
    .done    (done),
    .rd      (rd)
  );

  always #5 clk = ~clk;

  logic [11:0] mem [FRAMES][POINTS];
  word_t       exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: word = 16*f+p, mode 1: all 0xFFF, otherwise random
  task automatic load_storage(input int mode);
    for (int f = 0; f < FRAMES; f++) begin
      for (int p = 0; p < POINTS; p++) begin
        if (mode == 0)      mem[f][p] = 12'(16*f + p);
        else if (mode == 1) mem[f][p] = 12'hFFF;
        else                mem[f][p] = 12'($urandom_range(0, 4095));
        storage[12*(POINTS*f+p) +: 12] = mem[f][p];
      end
    end
  endtask

  // Readout order: every raw word frame-major, then the column sums when enabled.
  task automatic build_expected();
    int idx;
    int s;
    idx = 0;
    exp_q.delete();
    for (int f = 0; f < FRAMES; f++) begin
      for (int p = 0; p < POINTS; p++) begin
        exp_q.push_back('{16'(mem[f][p]), 4'(f), 11'(p), (idx == NWORDS-1)});
        idx++;
      end
    end
    if (SUM_EN) begin
      for (int p = 0; p < POINTS; p++) begin
        s = 0;
        for (int f = 0; f < FRAMES; f++) s += int'(mem[f][p]);
        exp_q.push_back('{16'(s), 4'd15, 11'(p), (idx == NWORDS-1)});
        idx++;
      end
    end
  endtask

  // rmode 0: ready always, 1: ready 0,1 alternating, 2: random ready
  task automatic run_readout(input string tag, input int rmode, input bit clobber, input bit poke);
    int    cyc, vcyc, got, last_acc;
    bit    finished, hold;
    word_t held, cur, w;
    build_expected();
    cyc = 0; vcyc = 0; got = 0; last_acc = -1; finished = 1'b0; hold = 1'b0;
    held = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (clobber) storage = '1;
    check({tag, " valid after start"}, 32'(rd.out_valid), 32'd1);
    while (!finished && cyc < 400) begin
      start = poke && (cyc == 6 || done);
      if (rmode == 0)      rd.out_ready = 1'b1;
      else if (rmode == 1) rd.out_ready = (cyc % 2 == 1);
      else                 rd.out_ready = 1'($urandom_range(0, 1));
      cur = '{rd.out_data, rd.out_frame, rd.out_point, rd.out_last};
      if (done) begin
        check({tag, " done latency"}, 32'(cyc), 32'(last_acc + 1));
        check({tag, " word count"}, 32'(got), 32'(NWORDS));
        check({tag, " valid in done"}, 32'(rd.out_valid), 32'd0);
        check({tag, " busy in done"}, 32'(busy), 32'd1);
        finished = 1'b1;
      end else begin
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " valid"}, 32'(rd.out_valid), 32'd1);
        if (hold) check({tag, " hold"}, 32'(cur), 32'(held));
        if (rd.out_valid) vcyc++;
        if (rd.out_valid && rd.out_ready) begin
          if (exp_q.size() == 0) begin
            check({tag, " extra word"}, 32'(got), 32'(NWORDS - 1));
          end else begin
            w = exp_q.pop_front();
            check($sformatf("%s word %0d {data,frame,point,last}", tag, got), 32'(cur), 32'(w));
          end
          got++;
          last_acc = cyc;
          hold = 1'b0;
        end else begin
          hold = rd.out_valid;
          held = cur;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    rd.out_ready = 1'b0;
    check({tag, " finished"}, 32'(finished), 32'd1);
    check({tag, " valid cycles"}, 32'(vcyc), 32'(rmode == 1 ? 2*NWORDS : (rmode == 0 ? NWORDS : vcyc)));
    repeat (3) begin
      check({tag, " idle busy"}, 32'(busy), 32'd0);
      check({tag, " idle done"}, 32'(done), 32'd0);
      check({tag, " idle valid"}, 32'(rd.out_valid), 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    word_t w7;
    rd.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy",  32'(busy),         32'd0);
    check("reset done",  32'(done),         32'd0);
    check("reset valid", 32'(rd.out_valid), 32'd0);
    check("reset data",  32'(rd.out_data),  32'd0);
    check("reset frame", 32'(rd.out_frame), 32'd0);
    check("reset point", 32'(rd.out_point), 32'd0);
    check("reset last",  32'(rd.out_last),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    load_storage(0);
    run_readout("ramp", 0, 1'b0, 1'b0);
    run_readout("backpressure", 1, 1'b0, 1'b0);
    load_storage(0);
    run_readout("snapshot", 0, 1'b1, 1'b0);
    load_storage(1);
    run_readout("all fff", 2, 1'b0, 1'b0);
    load_storage(2);
    run_readout("ignore start", 0, 1'b0, 1'b1);
    repeat (3) begin
      load_storage(2);
      run_readout("random", 2, 1'b0, 1'b0);
    end

    // Reset while word 7 is presented.
    load_storage(0);
    build_expected();
    w7 = exp_q[7];
    rd.out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("word 7 before reset", 32'({rd.out_frame, rd.out_point}), 32'({w7.f, w7.p}));
    rst_n = 1'b0;
    #1;
    check("reset valid at once", 32'(rd.out_valid), 32'd0);
    check("reset busy at once",  32'(busy),         32'd0);
    check("reset no done",       32'(done),         32'd0);
    rd.out_ready = 1'b0;
    @(negedge clk);
    check("reset hold done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post reset busy", 32'(busy), 32'd0);
    check("post reset done", 32'(done), 32'd0);
    run_readout("after reset", 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/storage_reader.md
# storage_reader

Read-side counterpart of the result storage block. On a `start` pulse it snapshots the flat storage bus, which holds FRAMES frames of POINTS 12-bit division results, and streams every word out over a valid/ready interface. Words are sent frame by frame, point by point, each tagged with its frame and point index. It sits between the storage register and the host/UART readout path, so the storage can keep shifting while a readout is in progress.

## Interface
- `POINTS`, 10, points per frame (1..2047)
- `FRAMES`, 10, frames held in storage (1..16)
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  readout request, sampled only in IDLE
- `storage`  in  12*POINTS*FRAMES  flat storage bus; frame f = bits [12*POINTS*(f+1)-1 -: 12*POINTS] (f=0 newest); point p of a frame = bits [12*p+11 -: 12]
- `busy`  out  1  high in every state except IDLE
- `out_valid`  out  1  word available
- `out_ready`  in  1  consumer accepts the word when high with `out_valid`
- `out_data`  out  16  word; raw samples zero-extended from 12 bits
- `out_frame`  out  4  frame index of the word (15 = sum word, see Configuration)
- `out_point`  out  11  point index of the word
- `out_last`  out  1  high on the final word of the readout
- `done`  out  1  one-cycle pulse after the final word is accepted

## Operation
- States: IDLE, STREAM, SUM (only when the macro is defined), DONE.
- IDLE: when `start`=1, copy `storage` into the internal snapshot, clear the frame and point counters, and go to STREAM. Later changes on `storage` do not affect the readout.
- STREAM: `out_valid`=1, `out_data`={4'b0, snapshot word[frame][point]}.
  - On each accept (`out_valid`&`out_ready`): point+1. On point=POINTS-1, point wraps to 0 and frame+1.
  - On accepting frame=FRAMES-1, point=POINTS-1: go to SUM if the macro is compiled in, else to DONE.
- SUM: POINTS words, `out_frame`=15, `out_data` = 16-bit sum of that point across all FRAMES snapshot frames. The maximum is 16*4095 = 65520, so there is no overflow. On accepting point POINTS-1, go to DONE.
- DONE: `done`=1 and `out_valid`=0 for one cycle, then IDLE.
- `out_last`=1 only while the final word of the readout is presented.
- `start` is ignored while `busy`=1. A `start` in the DONE cycle is also ignored.
- Reset mid-readout: return to IDLE immediately, drop the word in flight, and do not pulse `done`.
- Reset values: `busy`=0, `out_valid`=0, `out_data`=0, `out_frame`=0, `out_point`=0, `out_last`=0, `done`=0, counters 0, snapshot 0.

## Timing
- `start` high at edge N (IDLE) -> `busy` and `out_valid` high after edge N, showing frame 0 point 0.
- With `out_ready` held at 1: one word per cycle, no bubbles, including the STREAM->SUM transition.
- Total length: FRAMES*POINTS words, plus POINTS when the sum is enabled.
- Hold rule: while `out_valid`=1 and `out_ready`=0, `out_data`, `out_frame`, `out_point` and `out_last` stay stable.
- `out_valid` does not depend combinationally on `out_ready`. `out_ready` may toggle freely.
- `done` is high in the cycle after the edge that accepts the last word. `busy` falls one cycle later.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `STORAGE_READER_SUM_EN` defined: the SUM state, the per-point adder tree and the POINTS trailing sum words are included. `out_last` marks the last sum word.
- Not defined: no SUM state and no adders. `out_last` marks frame FRAMES-1 point POINTS-1, and `out_frame` never reads 15.

## Test plan
- Readout, POINTS=2, FRAMES=10, frame f point p = 16*f+p, `out_ready`=1 -> 20 words 0x0000, 0x0001, 0x0010, … 0x0091 in order. `out_last` is set on 0x0091. `done` pulses one cycle later.
- Backpressure: `out_ready` alternates 1,0 -> same sequence, each word held stable for two cycles, 40 cycles of valid data.
- Snapshot: `storage` is forced to all 0xFFF one cycle after `start` -> output is still the original values.
- Sum, macro on, all words 0xFFF, POINTS=2 -> after the 20 raw words, two words 0x9FF6 with `out_frame`=15. `out_last` is set on the second.
- Ignore rule: `start` pulsed during STREAM and in the DONE cycle -> no restart, exactly one `done`.
- Reset: `rst_n` is asserted low at word 7 -> `out_valid` and `busy` are 0 at once, with no `done`. A new `start` after release streams again from frame 0 point 0.
